// File: rtl/base_output_ser.sv
// rtl/base_output_ser.sv - parallel-to-serial output stage with output delay line
module base_output_ser #(
  parameter int w = 2,
  parameter int d = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_v,
  output logic         i_r,
  input  logic [0:w-1] i_d,
  output logic         o_d,
  output logic         o_sync,
  output logic         o_busy
);

  localparam int cw = (w > 1) ? $clog2(w) : 1;
  localparam logic [cw-1:0] cnt_last = cw'(w - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state;
  state_t        state_nx;
  logic [0:w-1]  sr;
  logic [cw-1:0] cnt;
  logic          last_bit;
  logic          xfer;
  logic          ser_d;
  logic          ser_sync;

  // State register; a reset mid-word drops the partial word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Handshake, next state and pre-delay serial outputs.
  // Ready is offered in IDLE and on the last bit of a word, so a word
  // presented during the last bit is loaded without an idle bubble.
  always_comb begin
    state_nx = state;
    last_bit = (state == SHIFT) && (cnt == '0);
    i_r      = !reset && ((state == IDLE) || last_bit);
    xfer     = i_v && i_r;
    ser_d    = 1'b0;
    ser_sync = 1'b0;
    o_busy   = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) state_nx = SHIFT;
      end
      SHIFT: begin
        ser_d    = sr[cnt];
        ser_sync = (cnt == cnt_last);
        o_busy   = 1'b1;
        if (last_bit && !xfer) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Word register and bit index; highest index goes out first so that a
  // receiver shifting into index 0 ends up with the identical word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (xfer) begin
      sr  <= i_d;
      cnt <= cnt_last;
    end else if ((state == SHIFT) && (cnt != '0)) begin
      cnt <= cnt - cw'(1);
    end
  end

  generate
    if (d == 0) begin : g_direct
      assign o_d    = ser_d;
      assign o_sync = ser_sync;
    end else begin : g_delay
      logic [d-1:0] dl_d;
      logic [d-1:0] dl_s;

      // Output delay line toward the pad, data and frame marker in lockstep.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          dl_d <= '0;
          dl_s <= '0;
        end else begin
          dl_d[0] <= ser_d;
          dl_s[0] <= ser_sync;
          for (int i = 1; i < d; i++) begin
            dl_d[i] <= dl_d[i-1];
            dl_s[i] <= dl_s[i-1];
          end
        end
      end

      assign o_d    = dl_d[d-1];
      assign o_sync = dl_s[d-1];
    end
  endgenerate

endmodule

// File: tb/tb_base_output_ser.sv
// tb/tb_base_output_ser.sv - self-checking bench for base_output_ser
module tb_base_output_ser;

  localparam int N = 1000;

  logic clk;
  logic reset;
  int   edge_n;
  int   checks;
  int   errors;

  // w=4 d=1
  logic       a_v, a_r, a_od, a_os, a_ob;
  logic [0:3] a_d;
  // w=4 d=0
  logic       b_v, b_r, b_od, b_os, b_ob;
  logic [0:3] b_d;
  // w=8 d=1
  logic       c_v, c_r, c_od, c_os, c_ob;
  logic [0:7] c_d;
  // loopback lane 0: w=1 d=1
  logic       lv0, l0_r, l0_od, l0_os, l0_ob;
  logic [0:0] ld0;
  // loopback lane 1: w=5 d=0
  logic       lv1, l1_r, l1_od, l1_os, l1_ob;
  logic [0:4] ld1;

  base_output_ser #(.w(4), .d(1)) u_a (.clk(clk), .reset(reset), .i_v(a_v), .i_r(a_r), .i_d(a_d),
    .o_d(a_od), .o_sync(a_os), .o_busy(a_ob));
  base_output_ser #(.w(4), .d(0)) u_b (.clk(clk), .reset(reset), .i_v(b_v), .i_r(b_r), .i_d(b_d),
    .o_d(b_od), .o_sync(b_os), .o_busy(b_ob));
  base_output_ser #(.w(8), .d(1)) u_c (.clk(clk), .reset(reset), .i_v(c_v), .i_r(c_r), .i_d(c_d),
    .o_d(c_od), .o_sync(c_os), .o_busy(c_ob));
  base_output_ser #(.w(1), .d(1)) u_l0 (.clk(clk), .reset(reset), .i_v(lv0), .i_r(l0_r), .i_d(ld0),
    .o_d(l0_od), .o_sync(l0_os), .o_busy(l0_ob));
  base_output_ser #(.w(5), .d(0)) u_l1 (.clk(clk), .reset(reset), .i_v(lv1), .i_r(l1_r), .i_d(ld1),
    .o_d(l1_od), .o_sync(l1_os), .o_busy(l1_ob));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    logic [0:3] din;
    logic [3:0] exp;   // bits in send order, exp[3] first
  } vec_t;
  vec_t tbl[7];

  int lane_w[2] = '{1, 5};
  int lane_d[2] = '{1, 0};
  int lane_word[2];
  int sent[2], wp[2], rp[2], rx_cnt[2], rx_val[2];
  bit rx_act[2], pend[2];
  int fw[2][16];
  int ft[2][16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h want %0h", nm, edge_n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lane_step(input int l);
    logic v, r, od, os;
    int   w, dd, mask, word;
    w    = lane_w[l];
    dd   = lane_d[l];
    mask = (1 << w) - 1;
    word = lane_word[l];
    if (l == 0) begin v = lv0; r = l0_r; od = l0_od; os = l0_os; end
    else        begin v = lv1; r = l1_r; od = l1_od; os = l1_os; end
    // receiver: input latch shifting new bits into index 0, framed by o_sync
    if (os) begin
      rx_act[l] = 1'b1;
      rx_cnt[l] = 0;
      rx_val[l] = 0;
    end
    if (rx_act[l]) begin
      rx_val[l] = ((rx_val[l] << 1) | int'(od)) & mask;
      rx_cnt[l]++;
      if (rx_cnt[l] == w) begin
        rx_act[l] = 1'b0;
        chk("lb_sync_has_word", (wp[l] - rp[l]) > 0, 1'b1);
        if (wp[l] > rp[l]) begin
          chk("lb_data", rx_val[l], fw[l][rp[l] % 16]);
          chk("lb_time", edge_n + 1, ft[l][rp[l] % 16] + w + dd);
          rp[l]++;
        end
      end
    end else begin
      chk("lb_idle_line", od, 1'b0);
    end
    // driver: random gaps, random churn of i_d while not ready
    if (pend[l]) begin
      v = 1'b0;
      pend[l] = 1'b0;
    end
    if (!v) begin
      if (sent[l] < N && $urandom_range(0, 2) != 0) begin
        v = 1'b1;
        word = int'($urandom) & mask;
      end
    end else if (!r && $urandom_range(0, 3) == 0) begin
      word = int'($urandom) & mask;
    end
    if (v && r) begin
      fw[l][wp[l] % 16] = word;
      ft[l][wp[l] % 16] = edge_n + 1;
      wp[l]++;
      sent[l]++;
      pend[l] = 1'b1;
    end
    lane_word[l] = word;
    if (l == 0) begin
      lv0 = v;
      ld0[0] = word[0];
    end else begin
      lv1 = v;
      for (int i = 0; i < 5; i++) ld1[i] = word[i];
    end
  endtask

  initial begin
    logic [7:0] bexp;
    logic [7:0] cexp;
    checks = 0;
    errors = 0;
    tbl[0] = '{din: 4'b1011, exp: 4'b1101};
    tbl[1] = '{din: 4'b1000, exp: 4'b0001};
    tbl[2] = '{din: 4'b0001, exp: 4'b1000};
    tbl[3] = '{din: 4'b1111, exp: 4'b1111};
    tbl[4] = '{din: 4'b0110, exp: 4'b0110};
    tbl[5] = '{din: 4'b0000, exp: 4'b0000};
    tbl[6] = '{din: 4'b1100, exp: 4'b0011};
    for (int l = 0; l < 2; l++) begin
      sent[l] = 0; wp[l] = 0; rp[l] = 0; rx_cnt[l] = 0; rx_val[l] = 0;
      rx_act[l] = 1'b0; pend[l] = 1'b0; lane_word[l] = 0;
    end

    reset = 1'b1;
    a_v = 1'b1; a_d = 4'hF;
    b_v = 1'b0; b_d = '0;
    c_v = 1'b0; c_d = '0;
    lv0 = 1'b0; ld0 = '0;
    lv1 = 1'b0; ld1 = '0;
    repeat (3) tick();

    // reset state with i_v high
    chk("rst_ir", a_r, 1'b0);
    chk("rst_od", a_od, 1'b0);
    chk("rst_sync", a_os, 1'b0);
    chk("rst_busy", a_ob, 1'b0);
    a_v = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_ir_a", a_r, 1'b1);
    chk("rel_ir_l0", l0_r, 1'b1);
    repeat (3) begin
      tick();
      chk("rel_quiet_od", a_od, 1'b0);
      chk("rel_quiet_sync", a_os, 1'b0);
      chk("rel_quiet_busy", a_ob, 1'b0);
    end

    // table: single words on w=4 d=1
    for (int e = 0; e < 7; e++) begin
      a_d = tbl[e].din;
      a_v = 1'b1;
      chk("tbl_ready_idle", a_r, 1'b1);
      tick();
      a_v = 1'b0;
      a_d = ~tbl[e].din;
      chk("tbl_busy", a_ob, 1'b1);
      chk("tbl_ir_shift", a_r, 1'b0);
      tick();
      for (int k = 0; k < 4; k++) begin
        chk("tbl_bit", a_od, tbl[e].exp[3-k]);
        chk("tbl_sync", a_os, k == 0);
        tick();
      end
      chk("tbl_tail_od", a_od, 1'b0);
      chk("tbl_tail_sync", a_os, 1'b0);
      chk("tbl_tail_busy", a_ob, 1'b0);
    end

    // back-to-back on w=4 d=0 with i_d churn while not ready
    bexp = 8'b01011010;
    b_d = 4'hA;
    b_v = 1'b1;
    chk("b2b_ready", b_r, 1'b1);
    tick();
    for (int k = 0; k < 8; k++) begin
      case (k)
        0: b_d = 4'hF;
        1: b_d = 4'h0;
        2: b_d = 4'h3;
        3: b_d = 4'h5;
        default: begin b_v = 1'b0; b_d = 4'hC; end
      endcase
      chk("b2b_bit", b_od, bexp[7-k]);
      chk("b2b_sync", b_os, (k == 0) || (k == 4));
      chk("b2b_busy", b_ob, 1'b1);
      chk("b2b_ir", b_r, (k == 3) || (k == 7));
      tick();
    end
    chk("b2b_tail_od", b_od, 1'b0);
    chk("b2b_tail_sync", b_os, 1'b0);
    chk("b2b_tail_busy", b_ob, 1'b0);
    chk("b2b_tail_ir", b_r, 1'b1);

    // mid-word reset on w=8 d=1
    c_d = 8'b11100101;
    c_v = 1'b1;
    tick();
    c_v = 1'b0;
    tick();
    chk("mid_bit0", c_od, 1'b1);
    chk("mid_sync0", c_os, 1'b1);
    tick();
    chk("mid_bit1", c_od, 1'b0);
    tick();
    chk("mid_bit2", c_od, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_od", c_od, 1'b0);
    chk("mid_rst_sync", c_os, 1'b0);
    chk("mid_rst_busy", c_ob, 1'b0);
    chk("mid_rst_ir", c_r, 1'b0);
    c_d = 8'hFF;
    c_v = 1'b1;
    tick();
    chk("rst_wins_busy", c_ob, 1'b0);
    c_v = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rel_ir", c_r, 1'b1);
    chk("mid_rel_od", c_od, 1'b0);
    tick();
    chk("mid_rel_busy", c_ob, 1'b0);
    chk("mid_rel_od2", c_od, 1'b0);
    cexp = 8'b01001101;
    c_d = 8'b10110010;
    c_v = 1'b1;
    tick();
    c_v = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("mid_new_bit", c_od, cexp[7-k]);
      chk("mid_new_sync", c_os, k == 0);
      tick();
    end
    chk("mid_new_tail", c_od, 1'b0);

    // loopback w=1 and w=5 with random gaps
    for (int cyc = 0; cyc < 40000; cyc++) begin
      if (rp[0] == N && rp[1] == N) break;
      lane_step(0);
      lane_step(1);
      tick();
    end
    chk("lb_count_w1", rp[0], N);
    chk("lb_count_w5", rp[1], N);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
